mem_access_ctrl: RTL and testbench

// Sequencer/arbiter in front of one single-port word memory (DATA_SIZE x WORDS).

---
 rtl/mem_access_ctrl_pkg.sv | 22 ++
 rtl/mem_access_ctrl_if.sv | 27 ++
 rtl/mem_access_ctrl_rr_arb2.sv | 25 ++
 rtl/mem_access_ctrl.sv | 127 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg
//   Shared definitions for the memory access controller slice:
//   controller state encodings, requester port indices and a small
//   helper that turns a one-hot two-port grant into a port index.
package mem_access_ctrl_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_CLEAR = 1'b0;
  localparam state_t ST_RUN   = 1'b1;

  localparam int P0 = 0;
  localparam int P1 = 1;

  // One bit is enough to name the winner of a two-port arbiter.
  typedef logic port_idx_t;

  function automatic port_idx_t gnt_to_idx(input logic [1:0] gnt);
    return gnt[P1];
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if
//   Request/grant/read-return bundle for one requester of the shared
//   word memory.
//   req    requester -> ctrl  access request, held until granted
//   we     requester -> ctrl  1 = write, 0 = read
//   addr   requester -> ctrl  word address [AW+1:2]
//   wdata  requester -> ctrl  write data
//   gnt    ctrl -> requester  combinational grant, transfer at req&gnt edge
//   rvalid ctrl -> requester  one-cycle pulse after a granted read
//   rdata  ctrl -> requester  read data, held until the next read
interface mem_access_ctrl_if #(
  parameter int DATA_SIZE = 32,
  parameter int WORDS     = 1024
);
  localparam int AW = $clog2(WORDS);

  logic                 req;
  logic                 we;
  logic [AW+1:2]        addr;
  logic [DATA_SIZE-1:0] wdata;
  logic                 gnt;
  logic                 rvalid;
  logic [DATA_SIZE-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_access_ctrl_rr_arb2.sv
// rr_arb2
//   Two-requester round-robin arbiter, purely combinational.
//   req[1:0]  request vector
//   last      index of the port that won the previous granted cycle
//   en        arbitration enable; gnt is all-zero when low
//   gnt[1:0]  one-hot grant
module rr_arb2
  import mem_access_ctrl_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       en,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (en) begin
      // Under contention the port that did not win last time goes next.
      if (req == 2'b11) gnt[last ? P0 : P1] = 1'b1;
      else              gnt = req;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Sequencer/arbiter in front of a single-port word memory. After reset
//   (or a clear_req pulse) it sweeps every word to zero, one per cycle,
//   then arbitrates two requesters round-robin onto the memory port.
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   clear_req    pulse: restart the clear sweep from word 0
//   busy         high while the clear sweep runs
//   p0, p1       requester bundles (slave side)
//   mem_addr     memory word address
//   mem_wdata    memory write data
//   mem_read_en  memory read enable
//   mem_write_en memory write enable
//   mem_rdata    memory read data (combinational read)
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int WORDS     = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear_req,
  output logic                      busy,
  mem_access_ctrl_if.slave          p0,
  mem_access_ctrl_if.slave          p1,
  output logic [$clog2(WORDS)+1:2]  mem_addr,
  output logic [DATA_SIZE-1:0]      mem_wdata,
  output logic                      mem_read_en,
  output logic                      mem_write_en,
  input  logic [DATA_SIZE-1:0]      mem_rdata
);

  localparam int AW = $clog2(WORDS);
  localparam logic [AW-1:0] LAST_WORD = AW'(WORDS - 1);

  state_t               state_q;
  logic [AW-1:0]        clr_cnt;
  port_idx_t            last_gnt;
  logic                 run;
  logic [1:0]           req;
  logic [1:0]           gnt;
  logic [1:0]           rd_hit;
  logic [1:0]           rvalid_q;
  logic [DATA_SIZE-1:0] rdata0_q;
  logic [DATA_SIZE-1:0] rdata1_q;

  assign run  = (state_q == ST_RUN);
  assign busy = ~run;
  assign req  = {p1.req, p0.req};

  rr_arb2 u_arb (
    .req  (req),
    .last (last_gnt),
    .en   (run),
    .gnt  (gnt)
  );

  assign p0.gnt    = gnt[P0];
  assign p1.gnt    = gnt[P1];
  assign rd_hit[P0] = gnt[P0] & ~p0.we;
  assign rd_hit[P1] = gnt[P1] & ~p1.we;

  // Memory port drive: sweep writes zeros, otherwise the granted port owns it.
  always_comb begin
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    if (!run) begin
      mem_addr     = clr_cnt;
      mem_write_en = 1'b1;
    end else if (gnt[P0]) begin
      mem_addr     = p0.addr;
      mem_wdata    = p0.wdata;
      mem_write_en = p0.we;
      mem_read_en  = ~p0.we;
    end else if (gnt[P1]) begin
      mem_addr     = p1.addr;
      mem_wdata    = p1.wdata;
      mem_write_en = p1.we;
      mem_read_en  = ~p1.we;
    end
  end

  // Control stage: sweep counter, state and round-robin history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_CLEAR;
      clr_cnt  <= '0;
      last_gnt <= 1'b1;
    end else begin
      // clear_req wins in either state; a grant in the same cycle still completes.
      if (clear_req) begin
        state_q <= ST_CLEAR;
        clr_cnt <= '0;
      end else if (!run) begin
        if (clr_cnt == LAST_WORD) begin
          state_q <= ST_RUN;
          clr_cnt <= '0;
        end else begin
          clr_cnt <= clr_cnt + 1'b1;
        end
      end
      if (|gnt) last_gnt <= gnt_to_idx(gnt);
    end
  end

  // Read return stage: capture memory data at the grant edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rvalid_q <= rd_hit;
      if (rd_hit[P0]) rdata0_q <= mem_rdata;
      if (rd_hit[P1]) rdata1_q <= mem_rdata;
    end
  end

  assign p0.rvalid = rvalid_q[P0];
  assign p1.rvalid = rvalid_q[P1];
  assign p0.rdata  = rdata0_q;
  assign p1.rdata  = rdata1_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  localparam int DATA_SIZE = 32;
  localparam int WORDS     = 1024;
  localparam int AW        = $clog2(WORDS);

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 clear_req;
  logic                 busy;
  logic [AW+1:2]        mem_addr;
  logic [DATA_SIZE-1:0] mem_wdata;
  logic [DATA_SIZE-1:0] mem_rdata;
  logic                 mem_read_en;
  logic                 mem_write_en;

  mem_access_ctrl_if #(.DATA_SIZE(DATA_SIZE), .WORDS(WORDS)) p0_if ();
  mem_access_ctrl_if #(.DATA_SIZE(DATA_SIZE), .WORDS(WORDS)) p1_if ();

  mem_access_ctrl #(.DATA_SIZE(DATA_SIZE), .WORDS(WORDS)) dut (
    .clk          (clk),
    .reset        (reset),
    .clear_req    (clear_req),
    .busy         (busy),
    .p0           (p0_if),
    .p1           (p1_if),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory with combinational read.
  logic [DATA_SIZE-1:0] mem_arr [WORDS];
  always @(posedge clk) if (mem_write_en) mem_arr[mem_addr] <= mem_wdata;
  assign mem_rdata = mem_arr[mem_addr];

  // Reference model state.
  logic [DATA_SIZE-1:0] ref_mem [WORDS];
  logic                 ref_last;
  logic [DATA_SIZE-1:0] exp_rd [2];
  int total;
  int bad;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic rq, input logic we,
                       input logic [AW-1:0] ad, input logic [DATA_SIZE-1:0] wd);
    if (p == 0) begin
      p0_if.req = rq; p0_if.we = we; p0_if.addr = ad; p0_if.wdata = wd;
    end else begin
      p1_if.req = rq; p1_if.we = we; p1_if.addr = ad; p1_if.wdata = wd;
    end
  endtask

  function automatic logic [DATA_SIZE-1:0] rdata_of(input int p);
    return (p == 0) ? p0_if.rdata : p1_if.rdata;
  endfunction

  task automatic model_reset();
    ref_last  = 1'b1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  // Counts the sweep from word 0 and checks every cycle drives a zero write
  // to the next word with no grants; optionally raises a p1 read mid-sweep.
  task automatic check_sweep(input string tag, input int raise_p1_at);
    int cyc = 0;
    int err = 0;
    while (busy === 1'b1 && cyc < 3 * WORDS) begin
      if (mem_write_en !== 1'b1 || mem_read_en !== 1'b0 || mem_addr !== cyc[AW-1:0] ||
          mem_wdata !== '0 || p0_if.gnt !== 1'b0 || p1_if.gnt !== 1'b0) err++;
      if (cyc == raise_p1_at) drive(1, 1'b1, 1'b0, AW'(3), '0);
      cyc++;
      tick();
    end
    total++;
    if (cyc != WORDS) begin
      bad++; $display("FAIL %s_len got=%0d want=%0d", tag, cyc, WORDS);
    end
    total++;
    if (err != 0) begin
      bad++; $display("FAIL %s_drive bad_cycles got=%0d want=0", tag, err);
    end
    for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({busy, p1_if.gnt, p0_if.gnt, p1_if.rvalid, p0_if.rvalid, mem_write_en} !== 6'b100001 ||
        p0_if.rdata !== '0 || p1_if.rdata !== '0 || mem_addr !== '0) begin
      bad++;
      $display("FAIL reset_state got busy=%b gnt=%b%b rv=%b%b we=%b rd0=%0h rd1=%0h addr=%0d want busy=1 gnt=00 rv=00 we=1 rd=0 addr=0",
               busy, p1_if.gnt, p0_if.gnt, p1_if.rvalid, p0_if.rvalid, mem_write_en, p0_if.rdata, p1_if.rdata, mem_addr);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check_sweep("sweep_after_reset", -1);
    // First contention after reset must go to port 0.
    drive(0, 1'b1, 1'b0, AW'(0), '0);
    drive(1, 1'b1, 1'b0, AW'(1), '0);
    #1;
    total++;
    if ({p1_if.gnt, p0_if.gnt} !== 2'b01) begin
      bad++; $display("FAIL first_contention gnt got=%b want=01", {p1_if.gnt, p0_if.gnt});
    end
    tick();
    ref_last = 1'b0; exp_rd[0] = ref_mem[0];
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    begin
      int err = 0;
      for (int i = 0; i < WORDS; i++) begin
        drive(0, 1'b1, 1'b0, AW'(i), '0);
        #1;
        if (p0_if.gnt !== 1'b1) err++;
        tick();
        if (p0_if.rvalid !== 1'b1 || p0_if.rdata !== ref_mem[i]) err++;
      end
      drive(0, 1'b0, 1'b0, '0, '0);
      exp_rd[0] = ref_mem[WORDS-1];
      total++;
      if (err != 0) begin
        bad++; $display("FAIL read_all_zero bad_reads got=%0d want=0", err);
      end
    end
  endtask

  task automatic test_rw_basic();
    drive(0, 1'b1, 1'b1, AW'(5), 32'hDEADBEEF);
    #1;
    total++;
    if (p0_if.gnt !== 1'b1) begin bad++; $display("FAIL wr5_gnt got=%b want=1", p0_if.gnt); end
    tick();
    ref_mem[5] = 32'hDEADBEEF; ref_last = 1'b0;
    total++;
    if (p0_if.rvalid !== 1'b0) begin bad++; $display("FAIL wr5_no_rvalid got=%b want=0", p0_if.rvalid); end
    drive(0, 1'b1, 1'b0, AW'(5), '0);
    #1;
    total++;
    if (p0_if.gnt !== 1'b1) begin bad++; $display("FAIL rd5_gnt got=%b want=1", p0_if.gnt); end
    tick();
    exp_rd[0] = ref_mem[5];
    drive(0, 1'b0, 1'b0, '0, '0);
    total++;
    if (p0_if.rvalid !== 1'b1 || p0_if.rdata !== exp_rd[0]) begin
      bad++; $display("FAIL rd5_data got rv=%b data=%0h want rv=1 data=%0h", p0_if.rvalid, p0_if.rdata, exp_rd[0]);
    end
    tick();
    total++;
    if (p0_if.rvalid !== 1'b0 || p0_if.rdata !== exp_rd[0]) begin
      bad++; $display("FAIL rd5_hold got rv=%b data=%0h want rv=0 data=%0h", p0_if.rvalid, p0_if.rdata, exp_rd[0]);
    end
  endtask

  task automatic test_back_to_back();
    drive(1, 1'b1, 1'b1, AW'(6), 32'hA5A5_0606);
    #1;
    total++;
    if ({p1_if.gnt, p0_if.gnt} !== 2'b10) begin
      bad++; $display("FAIL p1_wr_gnt got=%b want=10", {p1_if.gnt, p0_if.gnt});
    end
    tick();
    ref_mem[6] = 32'hA5A5_0606; ref_last = 1'b1;
    drive(0, 1'b1, 1'b0, AW'(5), '0);
    drive(1, 1'b1, 1'b0, AW'(6), '0);
    for (int k = 0; k < 4; k++) begin
      int w = k % 2;
      logic [1:0] want_g = (w == 0) ? 2'b01 : 2'b10;
      #1;
      total++;
      if ({p1_if.gnt, p0_if.gnt} !== want_g) begin
        bad++; $display("FAIL b2b_gnt k=%0d got=%b want=%b", k, {p1_if.gnt, p0_if.gnt}, want_g);
      end
      tick();
      exp_rd[w] = ref_mem[(w == 0) ? 5 : 6];
      ref_last = w[0];
      total++;
      if ({p1_if.rvalid, p0_if.rvalid} !== want_g || rdata_of(w) !== exp_rd[w]) begin
        bad++; $display("FAIL b2b_rvalid k=%0d got rv=%b data=%0h want rv=%b data=%0h",
                        k, {p1_if.rvalid, p0_if.rvalid}, rdata_of(w), want_g, exp_rd[w]);
      end
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_random();
    logic                 pend [2];
    logic                 rq [2];
    logic                 we [2];
    logic [AW-1:0]        ad [2];
    logic [DATA_SIZE-1:0] wd [2];
    logic                 exp_v [2];
    logic [1:0]           exp_g;
    int                   w;
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int c = 0; c < 300; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p]) begin
          rq[p] = ($urandom_range(0, 3) != 0);
          we[p] = 1'($urandom_range(0, 1));
          ad[p] = AW'($urandom_range(0, 15));
          wd[p] = $urandom;
        end
        drive(p, rq[p], we[p], ad[p], wd[p]);
      end
      #1;
      if (rq[0] && rq[1]) w = (ref_last == 1'b1) ? 0 : 1;
      else if (rq[0])     w = 0;
      else if (rq[1])     w = 1;
      else                w = -1;
      exp_g = (w < 0) ? 2'b00 : ((w == 0) ? 2'b01 : 2'b10);
      total++;
      if ({p1_if.gnt, p0_if.gnt} !== exp_g) begin
        bad++; $display("FAIL rnd_gnt c=%0d got=%b want=%b", c, {p1_if.gnt, p0_if.gnt}, exp_g);
      end
      exp_v[0] = 1'b0; exp_v[1] = 1'b0;
      if (w >= 0) begin
        if (we[w]) ref_mem[ad[w]] = wd[w];
        else begin exp_rd[w] = ref_mem[ad[w]]; exp_v[w] = 1'b1; end
        ref_last = w[0];
      end
      pend[0] = rq[0] && (w != 0);
      pend[1] = rq[1] && (w != 1);
      tick();
      total++;
      if ({p1_if.rvalid, p0_if.rvalid} !== {exp_v[1], exp_v[0]} ||
          p0_if.rdata !== exp_rd[0] || p1_if.rdata !== exp_rd[1]) begin
        bad++;
        $display("FAIL rnd_read c=%0d got rv=%b rd0=%0h rd1=%0h want rv=%b rd0=%0h rd1=%0h", c,
                 {p1_if.rvalid, p0_if.rvalid}, p0_if.rdata, p1_if.rdata, {exp_v[1], exp_v[0]}, exp_rd[0], exp_rd[1]);
      end
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_clear_req();
    drive(0, 1'b1, 1'b1, AW'(7), 32'h0000_1234);
    tick();
    drive(0, 1'b0, 1'b0, '0, '0);
    ref_mem[7] = 32'h0000_1234; ref_last = 1'b0;
    // clear_req with a p1 write in the same cycle: the write is still granted.
    clear_req = 1'b1;
    drive(1, 1'b1, 1'b1, AW'(9), 32'h0000_5678);
    #1;
    total++;
    if (p1_if.gnt !== 1'b1) begin bad++; $display("FAIL clr_same_cycle_gnt got=%b want=1", p1_if.gnt); end
    tick();
    clear_req = 1'b0;
    drive(1, 1'b0, 1'b0, '0, '0);
    ref_mem[9] = 32'h0000_5678; ref_last = 1'b1;
    repeat (20) tick();
    total++;
    if (busy !== 1'b1 || mem_addr !== AW'(20)) begin
      bad++; $display("FAIL clr_progress got busy=%b addr=%0d want busy=1 addr=20", busy, mem_addr);
    end
    // A second pulse mid-sweep restarts from word 0.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check_sweep("sweep_restart", -1);
    drive(0, 1'b1, 1'b0, AW'(7), '0);
    tick();
    total++;
    if (p0_if.rvalid !== 1'b1 || p0_if.rdata !== ref_mem[7]) begin
      bad++; $display("FAIL clr_word7 got rv=%b data=%0h want rv=1 data=%0h", p0_if.rvalid, p0_if.rdata, ref_mem[7]);
    end
    drive(0, 1'b1, 1'b0, AW'(9), '0);
    tick();
    drive(0, 1'b0, 1'b0, '0, '0);
    exp_rd[0] = ref_mem[9]; ref_last = 1'b0;
    total++;
    if (p0_if.rvalid !== 1'b1 || p0_if.rdata !== exp_rd[0]) begin
      bad++; $display("FAIL clr_word9 got rv=%b data=%0h want rv=1 data=%0h", p0_if.rvalid, p0_if.rdata, exp_rd[0]);
    end
  endtask

  task automatic test_req_during_clear();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check_sweep("sweep_p1_wait", 10);
    total++;
    if ({p1_if.gnt, p0_if.gnt} !== 2'b10) begin
      bad++; $display("FAIL p1_served_at_busy_fall got=%b want=10", {p1_if.gnt, p0_if.gnt});
    end
    tick();
    drive(1, 1'b0, 1'b0, '0, '0);
    exp_rd[1] = ref_mem[3]; ref_last = 1'b1;
    total++;
    if (p1_if.rvalid !== 1'b1 || p1_if.rdata !== exp_rd[1]) begin
      bad++; $display("FAIL p1_wait_read got rv=%b data=%0h want rv=1 data=%0h", p1_if.rvalid, p1_if.rdata, exp_rd[1]);
    end
  endtask

  task automatic test_reset_abort();
    logic [DATA_SIZE-1:0] val = $urandom | 32'h1;
    drive(0, 1'b1, 1'b1, AW'(2), val);
    tick();
    ref_mem[2] = val;
    drive(0, 1'b1, 1'b0, AW'(2), '0);
    tick();
    drive(0, 1'b0, 1'b0, '0, '0);
    total++;
    if (p0_if.rvalid !== 1'b1 || p0_if.rdata !== val) begin
      bad++; $display("FAIL abort_setup_read got rv=%b data=%0h want rv=1 data=%0h", p0_if.rvalid, p0_if.rdata, val);
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (p0_if.rvalid !== 1'b0 || p0_if.rdata !== '0 || busy !== 1'b1) begin
      bad++; $display("FAIL abort_access got rv=%b data=%0h busy=%b want rv=0 data=0 busy=1", p0_if.rvalid, p0_if.rdata, busy);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    repeat (500) tick();
    total++;
    if (busy !== 1'b1 || mem_addr !== AW'(500)) begin
      bad++; $display("FAIL sweep_500 got busy=%b addr=%0d want busy=1 addr=500", busy, mem_addr);
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (busy !== 1'b1 || mem_addr !== '0 || mem_write_en !== 1'b1 || {p1_if.gnt, p0_if.gnt} !== 2'b00) begin
      bad++; $display("FAIL abort_sweep got busy=%b addr=%0d we=%b gnt=%b want busy=1 addr=0 we=1 gnt=00",
                      busy, mem_addr, mem_write_en, {p1_if.gnt, p0_if.gnt});
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check_sweep("sweep_after_abort", -1);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    clear_req = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    test_reset();
    test_rw_basic();
    test_back_to_back();
    test_random();
    test_clear_req();
    test_req_during_clear();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
